// File: rtl/reu_pkg.sv
// Shared types and constants for the REU RAM slot.
package reu_pkg;

    localparam int REU_WIN_LEN    = 4;   // ram_cycle-high clocks per access window
    localparam int REU_GAP_LEN    = 2;   // ram_cycle-low clocks after each window
    localparam int REU_RD_LAT_MAX = 2;   // latest accepted mem_cmd-to-mem_rvalid distance
    localparam int REU_ADDR_W     = 25;  // REU address width, bit 24 selects the REU region

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WIN  = 2'd2,
        GAP  = 2'd3
    } reu_state_e;

endpackage

// File: rtl/reu_ram_slot.sv
// REU RAM slot: opens one ram_cycle window at a time for the REU and bridges
// each window onto an arbitrated expansion-memory port (one command per window).
module reu_ram_slot
    import reu_pkg::*;
#(
    parameter int WIN_LEN    = REU_WIN_LEN,
    parameter int GAP_LEN    = REU_GAP_LEN,
    parameter int RD_LAT_MAX = REU_RD_LAT_MAX
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  reu_active,
    output logic                  ram_cycle,
    input  logic [REU_ADDR_W-1:0] ram_addr,
    input  logic [7:0]            ram_dout,
    input  logic                  ram_we,
    output logic [7:0]            ram_din,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_cmd,
    output logic [REU_ADDR_W-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [7:0]            mem_rdata,
    output logic                  late_err
);

    // Last count value of the window / gap, and the slot at which an
    // outstanding read is declared late (end of W<RD_LAT_MAX>).
    localparam logic [2:0] WIN_LAST = 3'(WIN_LEN - 1);
    localparam logic [2:0] GAP_LAST = 3'(GAP_LEN - 1);
    localparam logic [2:0] LATE_AT  = 3'(RD_LAT_MAX);

    reu_state_e state_r;
    reu_state_e state_s;
    logic [2:0] wcnt_r;
    logic [2:0] wcnt_s;
    logic       rd_pend_r;
    logic       rd_pend_s;
    logic [7:0] ram_din_r;
    logic [7:0] ram_din_s;
    logic       late_err_r;
    logic       late_err_s;
    logic       ram_cycle_r;
    logic       mem_req_r;
    logic       cmd_s;

    // The single command strobe sits on W0; the REU signals are stable then
    // because the REU only changes them while ram_cycle is low.
    assign cmd_s     = (state_r == WIN) && (wcnt_r == 3'd0);
    assign mem_cmd   = cmd_s;
    assign mem_addr  = ram_addr;
    assign mem_we    = ram_we & cmd_s;
    assign mem_wdata = ram_dout;

    assign ram_cycle = ram_cycle_r;
    assign mem_req   = mem_req_r;
    assign ram_din   = ram_din_r;
    assign late_err  = late_err_r;

    // Next-state logic: IDLE -> REQ -> WIN(W0..W3) -> GAP -> REQ/IDLE, wcnt shared by WIN and GAP.
    always_comb begin
        state_s = state_r;
        wcnt_s  = wcnt_r;
        case (state_r)
            IDLE: begin
                if (reu_active) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                // A grant wins over a simultaneous reu_active drop: the window still runs.
                if (mem_gnt) begin
                    state_s = WIN;
                    wcnt_s  = 3'd0;
                end else if (!reu_active) begin
                    state_s = IDLE;
                end else begin
                    state_s = REQ;
                end
            end
            WIN: begin
                // The window always completes, even if the grant drops early.
                if (wcnt_r == WIN_LAST) begin
                    state_s = GAP;
                    wcnt_s  = 3'd0;
                end else begin
                    wcnt_s = wcnt_r + 3'd1;
                end
            end
            GAP: begin
                if (wcnt_r == GAP_LAST) begin
                    wcnt_s = 3'd0;
                    if (reu_active) begin
                        state_s = REQ;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    wcnt_s = wcnt_r + 3'd1;
                end
            end
            default: begin
                state_s = IDLE;
                wcnt_s  = 3'd0;
            end
        endcase
    end

    // Read tracking: capture the response, or flag it late at the deadline and keep stale data.
    always_comb begin
        rd_pend_s  = rd_pend_r;
        ram_din_s  = ram_din_r;
        late_err_s = late_err_r;
        if (cmd_s && !ram_we) begin
            if (mem_rvalid) begin
                ram_din_s = mem_rdata;
            end else if (LATE_AT == 3'd0) begin
                late_err_s = 1'b1;
            end else begin
                rd_pend_s = 1'b1;
            end
        end else if (rd_pend_r && mem_rvalid) begin
            ram_din_s = mem_rdata;
            rd_pend_s = 1'b0;
        end else if (rd_pend_r && (state_r == WIN) && (wcnt_r == LATE_AT)) begin
            late_err_s = 1'b1;
            rd_pend_s  = 1'b0;
        end else begin
            rd_pend_s = rd_pend_r;
        end
    end

    // State, counter and registered window/request outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            wcnt_r      <= 3'd0;
            ram_cycle_r <= 1'b0;
            mem_req_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            wcnt_r      <= wcnt_s;
            ram_cycle_r <= (state_s == WIN);
            mem_req_r   <= (state_s == REQ) || (state_s == WIN);
        end
    end

    // Read-data, pending-read and sticky late-error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_r  <= 1'b0;
            ram_din_r  <= 8'hFF;
            late_err_r <= 1'b0;
        end else begin
            rd_pend_r  <= rd_pend_s;
            ram_din_r  <= ram_din_s;
            late_err_r <= late_err_s;
        end
    end

endmodule
